adc_par_reader: RTL and testbench
=================================

# adc_par_reader

Parallel-bus ADC readout controller: the acquisition-side counterpart of the DAC7624 write driver. It sequences conversions on a 4-channel, 12-bit parallel ADC with CONVST/BUSY/CS/RD handshaking and stores one result per channel. Results are exposed through the same 8-bit register bus as the other slow-control blocks. Scans are started by a register command or by the step trigger from the counter logic.

## Interface
- `CONV_TIMEOUT`, 1000: maximum clocks spent waiting for end of conversion.
- `T_CONVST`, 2: clocks for which `adc_convst_n` is held low.
- `T_RD`, 3: clocks for which `adc_rd_n` is held low; data is sampled on the last of these clocks.
- `clk`  in  1  system clock, 50 MHz.
- `res`  in  1  reset, asynchronous, active-high.
- `we`  in  1  register write strobe.
- `addr`  in  8  register address.
- `data_in`  in  8  register write data.
- `data_out`  out  8  register read data, registered.
- `start_trig`  in  1  one-cycle scan request.
- `adc_a`  out  2  ADC channel select.
- `adc_convst_n`  out  1  conversion start, active low.
- `adc_cs_n`  out  1  chip select, active low.
- `adc_rd_n`  out  1  read strobe, active low.
- `adc_busy_n`  in  1  ADC busy, active low, asynchronous to `clk`.
- `adc_d`  in  12  ADC data bus.
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse at the end of each full scan.
- `timeout_err`  out  1  sticky conversion-timeout flag.

## Operation
- Register map:
  - 0x10 CTRL:
    - bit0 START, self-clearing, reads as 0.
    - bit1 CONT.
    - bits7:4 MASK, where bit4 selects channel 0.
  - 0x11 STATUS:
    - Read: {6'b0, timeout_err, busy}.
    - Any write clears `timeout_err`.
  - 0x12–0x19 results, two bytes per channel, channel 0 first:
    - Low byte is result[7:0].
    - High byte is {4'b0, result[11:8]}.
- Scan start:
  - A scan starts on START=1 or `start_trig`, but only in IDLE and only with MASK≠0. In any other state or with MASK=0 the request is ignored.
  - MASK is latched at scan start. Later CTRL writes affect the next scan only.
- Channel order: ascending index over the set mask bits. `adc_a` equals the channel index.
- `adc_busy_n` passes through a 2-flop synchronizer before use.
- FSM:
  - IDLE
  - SETUP: drive `adc_a`; lasts 1 clock.
  - CONV: `adc_convst_n` low for `T_CONVST` clocks.
  - WAIT: minimum 4 clocks, then wait for synced busy_n=1.
  - READ: `adc_cs_n` and `adc_rd_n` low for `T_RD` clocks; sample `adc_d` on the last clock.
  - STORE: write the result register; 1 clock.
  - NEXT: go to SETUP for the next masked channel. After the last channel, pulse `done` and go to IDLE, or to SETUP of the first channel if CONT=1.
- WAIT counter reaching `CONV_TIMEOUT`:
  - Set `timeout_err`.
  - Abort the scan to IDLE with no `done` pulse.
  - The current channel's result is left unchanged.
- Clearing CONT during a scan lets the current scan finish, then the block stops.
- Reset values:
  - `adc_convst_n`, `adc_cs_n`, `adc_rd_n` = 1.
  - `adc_a` = 0.
  - `busy`, `done`, `timeout_err` = 0.
  - `data_out` = 0.
  - All results = 0.
  - CTRL = 0.
- Reset mid-scan: all ADC strobes return high immediately (asynchronously), and the FSM goes to IDLE.
- Unmapped read addresses return 0x00.

## Timing
- A register read is valid one clock after `addr` is presented.
- `busy` rises the clock after the accepted start and falls in the same clock as `done`.
- Per-channel conversion latency is SETUP + `T_CONVST` + WAIT + `T_RD` + STORE + NEXT = 1+2+W+3+1+1 clocks, where W ≥ 4.
- `adc_cs_n` and `adc_rd_n` fall together and rise together.
- `adc_a` is stable from SETUP through STORE.
- A register write to a result address while that result is being stored: the STORE wins, and the write is ignored because results are read-only.

## Configuration
- `ADC_PAR_READER_AVG_EN`:
  - Defined: each channel is converted 4 times in succession (CONV→WAIT→READ repeated). The values are summed in a 14-bit accumulator and the stored result is sum[13:2].
  - A timeout on any of the 4 conversions aborts the scan as above.
- Undefined: one conversion per channel, stored as sampled.

## Test plan
- Reset, then MASK=0001, START, ADC model returns 0xABC with busy 10 clocks → regs 0x12/0x13 read 0xBC/0x0A, one `done` pulse, `busy` low after.
- MASK=1010, `start_trig` → `adc_a` sequence 1 then 3. Channel 0 and 2 results stay 0.
- `adc_busy_n` held low → `timeout_err`=1 after `CONV_TIMEOUT` clocks in WAIT, no `done`, IDLE. A write to 0x11 clears the flag.
- CONT=1, MASK=0001 → repeated scans with one `done` per scan. Clearing CONT stops after the current scan. A second START while busy is ignored.
- Assert `res` mid-READ → `adc_cs_n`/`adc_rd_n` high asynchronously, all outputs at reset values.
- With `ADC_PAR_READER_AVG_EN`, samples 100, 101, 102, 103 → stored 101.

Source files
------------

// File: rtl/adc_par_reader.sv
// adc_par_reader: readout controller for a 4-channel, 12-bit parallel ADC.
// It runs the CONVST/BUSY/CS/RD handshake, keeps one result per channel
// and exposes the results on the 8-bit slow-control register bus.
// Optional build macro ADC_PAR_READER_AVG_EN: each channel is converted 4 times
// and the stored result is the mean (sum[13:2]).
module adc_par_reader #(
  parameter int CONV_TIMEOUT = 1000,
  parameter int T_CONVST     = 2,
  parameter int T_RD         = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        we,
  input  logic [7:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        start_trig,
  output logic [1:0]  adc_a,
  output logic        adc_convst_n,
  output logic        adc_cs_n,
  output logic        adc_rd_n,
  input  logic        adc_busy_n,
  input  logic [11:0] adc_d,
  output logic        busy,
  output logic        done,
  output logic        timeout_err
);

  localparam int CW = $clog2(CONV_TIMEOUT + 1);
  localparam logic [CW-1:0] CONVST_LAST = CW'(T_CONVST - 1);
  localparam logic [CW-1:0] RD_LAST     = CW'(T_RD - 1);
  localparam logic [CW-1:0] WAIT_MIN    = CW'(3);
  localparam logic [CW-1:0] TO_LAST     = CW'(CONV_TIMEOUT - 1);

`ifdef ADC_PAR_READER_AVG_EN
  localparam int AW = 14;
`else
  localparam int AW = 12;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_CONV, S_WAIT, S_READ, S_STORE, S_NEXT
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        ch_q, ch_d;
  logic [3:0]        mask_q, mask_d;
  logic [7:0]        ctrl_q, ctrl_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [3:0][11:0]  rslt_q, rslt_d;
  logic              busy_s1_q, busy_s2_q;
  logic              convst_n_q, convst_n_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              tout_q, tout_d;
  logic [7:0]        dout_q, dout_d;
`ifdef ADC_PAR_READER_AVG_EN
  logic [1:0]        rep_q, rep_d;
`endif

  logic        wr_ctrl, start_req;
  logic [3:0]  eff_mask;
  logic [2:0]  first_hit, next_hit, cont_hit;
  logic [11:0] store_val;

  // Lowest set mask bit at index >= from; returns {found, index}.
  function automatic logic [2:0] find_from(input logic [3:0] m, input logic [2:0] from);
    find_from = 3'b000;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) find_from = {1'b1, 2'(i)};
  endfunction

  assign adc_a        = ch_q;
  assign adc_convst_n = convst_n_q;
  assign adc_cs_n     = cs_n_q;
  assign adc_rd_n     = rd_n_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_err  = tout_q;
  assign data_out     = dout_q;

`ifdef ADC_PAR_READER_AVG_EN
  assign store_val = acc_q[13:2];
`else
  assign store_val = acc_q;
`endif

  // Scan sequencer, register writes and the registered read mux.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    acc_d   = acc_q;
    rslt_d  = rslt_q;
    done_d  = 1'b0;
`ifdef ADC_PAR_READER_AVG_EN
    rep_d   = rep_q;
`endif

    // START is self-clearing, so bit0 is never stored.
    wr_ctrl   = we && (addr == 8'h10);
    ctrl_d    = wr_ctrl ? {data_in[7:1], 1'b0} : ctrl_q;
    start_req = (wr_ctrl && data_in[0]) || start_trig;
    // A START written together with a new MASK scans the new MASK.
    eff_mask  = wr_ctrl ? data_in[7:4] : ctrl_q[7:4];

    // Any STATUS write clears the flag; a timeout in the same clock wins.
    tout_d = (we && (addr == 8'h11)) ? 1'b0 : tout_q;

    first_hit = find_from(eff_mask, 3'd0);
    next_hit  = find_from(mask_q, {1'b0, ch_q} + 3'd1);
    cont_hit  = find_from(ctrl_q[7:4], 3'd0);

    case (state_q)
      S_IDLE: begin
        if (start_req && (eff_mask != 4'd0)) begin
          mask_d  = eff_mask;
          ch_d    = first_hit[1:0];
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d   = '0;
        acc_d   = '0;
`ifdef ADC_PAR_READER_AVG_EN
        rep_d   = 2'd0;
`endif
        state_d = S_CONV;
      end
      S_CONV: begin
        if (cnt_q == CONVST_LAST) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        // The first 4 clocks cover the synchronizer delay before BUSY shows up.
        if ((cnt_q >= WAIT_MIN) && busy_s2_q) begin
          cnt_d   = '0;
          state_d = S_READ;
        end else if (cnt_q == TO_LAST) begin
          tout_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_READ: begin
        if (cnt_q == RD_LAST) begin
          cnt_d = '0;
`ifdef ADC_PAR_READER_AVG_EN
          acc_d = acc_q + {2'b00, adc_d};
          if (rep_q == 2'd3) begin
            state_d = S_STORE;
          end else begin
            rep_d   = rep_q + 2'd1;
            state_d = S_CONV;
          end
`else
          acc_d   = adc_d;
          state_d = S_STORE;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        rslt_d[ch_q] = store_val;
        state_d      = S_NEXT;
      end
      S_NEXT: begin
        if (next_hit[2]) begin
          ch_d    = next_hit[1:0];
          state_d = S_SETUP;
        end else begin
          done_d = 1'b1;
          // Continuous mode picks up the current MASK for the following scan.
          if (ctrl_q[1] && cont_hit[2]) begin
            mask_d  = ctrl_q[7:4];
            ch_d    = cont_hit[1:0];
            state_d = S_SETUP;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are registered from the next state so they are glitch-free.
    convst_n_d = (state_d != S_CONV);
    cs_n_d     = (state_d != S_READ);
    rd_n_d     = (state_d != S_READ);
    busy_d     = (state_d != S_IDLE);

    case (addr)
      8'h10:   dout_d = ctrl_q;
      8'h11:   dout_d = {6'b0, tout_q, busy_q};
      8'h12:   dout_d = rslt_q[0][7:0];
      8'h13:   dout_d = {4'b0, rslt_q[0][11:8]};
      8'h14:   dout_d = rslt_q[1][7:0];
      8'h15:   dout_d = {4'b0, rslt_q[1][11:8]};
      8'h16:   dout_d = rslt_q[2][7:0];
      8'h17:   dout_d = {4'b0, rslt_q[2][11:8]};
      8'h18:   dout_d = rslt_q[3][7:0];
      8'h19:   dout_d = {4'b0, rslt_q[3][11:8]};
      default: dout_d = 8'h00;
    endcase
  end

  // State, outputs and BUSY synchronizer; reset forces strobes high at once.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ch_q       <= 2'd0;
      mask_q     <= 4'd0;
      ctrl_q     <= 8'h00;
      acc_q      <= '0;
      rslt_q     <= '0;
      busy_s1_q  <= 1'b1;
      busy_s2_q  <= 1'b1;
      convst_n_q <= 1'b1;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tout_q     <= 1'b0;
      dout_q     <= 8'h00;
`ifdef ADC_PAR_READER_AVG_EN
      rep_q      <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ch_q       <= ch_d;
      mask_q     <= mask_d;
      ctrl_q     <= ctrl_d;
      acc_q      <= acc_d;
      rslt_q     <= rslt_d;
      busy_s1_q  <= adc_busy_n;
      busy_s2_q  <= busy_s1_q;
      convst_n_q <= convst_n_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      tout_q     <= tout_d;
      dout_q     <= dout_d;
`ifdef ADC_PAR_READER_AVG_EN
      rep_q      <= rep_d;
`endif
    end
  end

endmodule

// File: tb/tb_adc_par_reader.sv
// Bench for adc_par_reader: ADC behavioural model, random scans, and a
// result scoreboard derived from the register map and scan rules.
module tb_adc_par_reader;
  localparam int TO = 1000;
`ifdef ADC_PAR_READER_AVG_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif

  logic        clk = 1'b0;
  logic        res, we, start_trig, adc_busy_n;
  logic [7:0]  addr, data_in;
  logic [7:0]  data_out;
  logic [1:0]  adc_a;
  logic        adc_convst_n, adc_cs_n, adc_rd_n, busy, done, timeout_err;
  logic [11:0] adc_d;

  adc_par_reader #(.CONV_TIMEOUT(TO), .T_CONVST(2), .T_RD(3)) dut (
    .clk(clk), .res(res), .we(we), .addr(addr), .data_in(data_in),
    .data_out(data_out), .start_trig(start_trig), .adc_a(adc_a),
    .adc_convst_n(adc_convst_n), .adc_cs_n(adc_cs_n), .adc_rd_n(adc_rd_n),
    .adc_busy_n(adc_busy_n), .adc_d(adc_d), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  always #10 clk = ~clk;

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ADC model: BUSY low from CONVST until busy_len clocks after CONVST rises.
  logic [11:0] adc_val [4];
  int  busy_len = 10;
  bit  busy_stuck = 0;
  int  bcnt = 0;
  int  conv_seq = 0;
  initial adc_busy_n = 1'b1;
  always @(posedge clk) begin
    if (!adc_convst_n) begin
      adc_busy_n <= 1'b0;
      bcnt       <= busy_len;
    end else if (!adc_busy_n && !busy_stuck) begin
      if (bcnt == 0) adc_busy_n <= 1'b1;
      else           bcnt <= bcnt - 1;
    end
  end
`ifdef ADC_PAR_READER_AVG_EN
  // Successive conversions of a channel return v, v+1, v+2, v+3.
  assign adc_d = adc_val[adc_a] + 12'((conv_seq - 1) % 4);
`else
  assign adc_d = adc_val[adc_a];
`endif

  // Monitor: channel of each conversion, done pulses, busy at done.
  bit conv_prev = 1'b1;
  logic [1:0] seen_a[$];
  int done_cnt = 0;
  bit cont_on = 0;
  always @(negedge clk) begin
    if (!adc_convst_n && conv_prev) begin
      seen_a.push_back(adc_a);
      conv_seq++;
    end
    conv_prev = adc_convst_n;
    if (done) begin
      done_cnt++;
      chk("busy_at_done", {31'b0, busy}, {31'b0, cont_on});
    end
  end

  // Reference model of stored results.
  logic [11:0] res_exp [4];
  function automatic logic [11:0] model_store(input logic [11:0] v);
    int sum = 0;
    for (int k = 0; k < REPS; k++) sum += int'(v) + ((REPS > 1) ? k : 0);
    return 12'(sum / REPS);
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); we = 1'b1; addr = a; data_in = d;
    @(negedge clk); we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk); addr = a;
    @(posedge clk); #1 d = data_out;
  endtask

  task automatic trig();
    @(negedge clk); start_trig = 1'b1;
    @(negedge clk); start_trig = 1'b0;
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int n = 0;
    while (done_cnt < target && n < bound) begin @(negedge clk); n++; end
    chk(tag, {31'b0, done_cnt >= target}, 32'd1);
  endtask

  task automatic wait_rd_low(input string tag);
    int n = 0;
    while (adc_rd_n !== 1'b0 && n < 500) begin @(negedge clk); n++; end
    chk(tag, {31'b0, adc_rd_n}, 32'd0);
  endtask

  task automatic check_results(input string tag);
    logic [7:0] b;
    for (int c = 0; c < 4; c++) begin
      rd(8'(8'h12 + 2 * c), b);
      chk({tag, "_lo"}, b, res_exp[c][7:0]);
      rd(8'(8'h13 + 2 * c), b);
      chk({tag, "_hi"}, b, {4'b0, res_exp[c][11:8]});
    end
  endtask

  task automatic run_scan(input logic [3:0] m, input bit use_trig, input string tag);
    int d0;
    logic [1:0] expq[$];
    seen_a.delete();
    d0 = done_cnt;
    if (use_trig) begin wr(8'h10, {m, 4'b0000}); trig(); end
    else wr(8'h10, {m, 4'b0001});
    wait_done(d0 + 1, 3000, {tag, "_done"});
    repeat (3) @(negedge clk);
    chk({tag, "_ndone"}, done_cnt - d0, 32'd1);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    for (int c = 0; c < 4; c++)
      if (m[c]) begin
        res_exp[c] = model_store(adc_val[c]);
        for (int k = 0; k < REPS; k++) expq.push_back(2'(c));
      end
    chk({tag, "_nconv"}, seen_a.size(), expq.size());
    for (int i = 0; i < expq.size() && i < seen_a.size(); i++)
      chk({tag, "_chan"}, {30'b0, seen_a[i]}, {30'b0, expq[i]});
    check_results(tag);
  endtask

  initial begin
    logic [7:0] b;
    int d0, d1, n;
    res = 1'b1; we = 1'b0; addr = 8'h00; data_in = 8'h00; start_trig = 1'b0;
    for (int c = 0; c < 4; c++) begin adc_val[c] = 12'h0; res_exp[c] = 12'h0; end
    repeat (3) @(negedge clk);
    chk("rst_convst", {31'b0, adc_convst_n}, 32'd1);
    chk("rst_cs",     {31'b0, adc_cs_n}, 32'd1);
    chk("rst_rd",     {31'b0, adc_rd_n}, 32'd1);
    chk("rst_a",      {30'b0, adc_a}, 32'd0);
    chk("rst_flags",  {29'b0, busy, done, timeout_err}, 32'd0);
    chk("rst_dout",   {24'b0, data_out}, 32'd0);
    res = 1'b0;
    rd(8'h10, b); chk("rst_ctrl", b, 8'h00);
    check_results("rst_res");

    // Single channel 0 with 0xABC; a second START while busy is ignored.
    adc_val[0] = 12'hABC; adc_val[1] = 12'h123; busy_len = 10;
    seen_a.delete(); d0 = done_cnt;
    wr(8'h10, 8'h11);
    repeat (4) @(negedge clk);
    wr(8'h10, 8'h21);
    wait_done(d0 + 1, 3000, "ch0_done");
    repeat (40) @(negedge clk);
    chk("ch0_ndone", done_cnt - d0, 32'd1);
    chk("ch0_nconv", seen_a.size(), REPS);
    if (seen_a.size() > 0) chk("ch0_chan", {30'b0, seen_a[0]}, 32'd0);
    res_exp[0] = model_store(12'hABC);
    check_results("ch0");

`ifdef ADC_PAR_READER_AVG_EN
    adc_val[0] = 12'd100;
    run_scan(4'b0001, 1'b0, "avg100");
    rd(8'h12, b); chk("avg100_val", b, 8'd101);
`endif

    // Channels 1 and 3 by trigger only.
    adc_val[1] = 12'(($urandom % 4093)); adc_val[3] = 12'(($urandom % 4093));
    run_scan(4'b1010, 1'b1, "mask1010");

    // Requests with MASK=0 are ignored.
    seen_a.delete();
    wr(8'h10, 8'h01);
    repeat (5) @(negedge clk);
    chk("mask0_busy", {31'b0, busy}, 32'd0);
    chk("mask0_nconv", seen_a.size(), 32'd0);

    // Randomized scans.
    for (int it = 0; it < 6; it++) begin
      busy_len = $urandom_range(0, 20);
      for (int c = 0; c < 4; c++) adc_val[c] = 12'($urandom % 4093);
      run_scan(4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)), "rand");
    end

    // Conversion timeout.
    busy_stuck = 1; d0 = done_cnt; adc_val[0] = 12'h555;
    wr(8'h10, 8'h11);
    n = 0;
    while (timeout_err !== 1'b1 && n < TO + 200) begin @(negedge clk); n++; end
    chk("to_flag", {31'b0, timeout_err}, 32'd1);
    chk("to_minwait", {31'b0, n >= TO}, 32'd1);
    repeat (3) @(negedge clk);
    chk("to_ndone", done_cnt - d0, 32'd0);
    chk("to_busy", {31'b0, busy}, 32'd0);
    rd(8'h11, b); chk("to_status", b, 8'h02);
    busy_stuck = 0;
    wr(8'h11, 8'h00);
    rd(8'h11, b); chk("to_clear", b, 8'h00);
    check_results("to_res");
    repeat (50) @(negedge clk);

    // Continuous mode, then clear CONT mid-scan.
    busy_len = 3; adc_val[0] = 12'h2C7; cont_on = 1; d0 = done_cnt;
    wr(8'h10, 8'h13);
    wait_done(d0 + 3, 1000, "cont_runs");
    wait_rd_low("cont_inread");
    cont_on = 0;
    d1 = done_cnt;
    wr(8'h10, 8'h10);
    wait_done(d1 + 1, 500, "cont_last");
    repeat (100) @(negedge clk);
    chk("cont_stop", done_cnt - d1, 32'd1);
    chk("cont_busy", {31'b0, busy}, 32'd0);
    res_exp[0] = model_store(12'h2C7);
    check_results("cont");

    // Reset in the middle of READ.
    for (int c = 0; c < 4; c++) adc_val[c] = 12'($urandom % 4093);
    wr(8'h10, 8'hF1);
    wait_rd_low("rst_inread");
    #3 res = 1'b1;
    #1;
    chk("arst_cs",     {31'b0, adc_cs_n}, 32'd1);
    chk("arst_rd",     {31'b0, adc_rd_n}, 32'd1);
    chk("arst_convst", {31'b0, adc_convst_n}, 32'd1);
    chk("arst_a",      {30'b0, adc_a}, 32'd0);
    chk("arst_flags",  {29'b0, busy, done, timeout_err}, 32'd0);
    chk("arst_dout",   {24'b0, data_out}, 32'd0);
    for (int c = 0; c < 4; c++) res_exp[c] = 12'h0;
    @(negedge clk); res = 1'b0;
    rd(8'h10, b); chk("arst_ctrl", b, 8'h00);
    check_results("arst");

    // Unmapped addresses.
    rd(8'h0F, b); chk("unmap_0f", b, 8'h00);
    rd(8'h1A, b); chk("unmap_1a", b, 8'h00);
    rd(8'hFF, b); chk("unmap_ff", b, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
